cpu_mc: RTL and testbench

- Multi-cycle RV32I core; parametrised successor to the single-cycle `cpu` top.
- Shares one memory port between instruction fetch and data access, using a req/ready handshake, so it tolerates wait-states.
- Register count is configurable (RV32I with 32 registers, or RV32E with 16).
- Adds precise halt/trap reporting and optional performance counters.

---
 rtl/cpu_mc.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_cpu_mc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I/RV32E core with one shared req/ready memory port.
// Sequence FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH; HALT is terminal
// until reset and reports illegal / misaligned / ECALL-EBREAK causes.
// Optional performance counters are built when the macro CPU_MC_PERF_EN is
// defined; otherwise cycle_cnt and instret_cnt are tied to zero.
module cpu_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_o,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    localparam bit RV32E = (NUM_REGS == 32'sd16);
    localparam int RW    = RV32E ? 32'sd4 : 32'sd5;

    generate
        if ((NUM_REGS != 32'sd32) && (NUM_REGS != 32'sd16)) begin : g_bad_num_regs
            $error("cpu_mc: NUM_REGS must be 32 or 16");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN   = 2'd2;
    localparam logic [1:0] CAUSE_TRAP    = 2'd3;

    // Architectural and pipeline-stage state
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_rs1v;
    logic [31:0] r_rs2v;
    logic [31:0] r_imm;
    logic [31:0] r_result;
    logic [31:0] r_next_pc;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_halted;
    logic [1:0]  r_cause;
    logic [31:0] r_regs [NUM_REGS];

    // Instruction fields (valid from DECODE through WB, r_ir is stable then)
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    logic        w_legal;
    logic        w_trap;
    logic        w_uses_rd;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic [31:0] w_imm;
    logic        w_reg_bad;
    logic        w_is_load;
    logic        w_is_store;

    assign w_is_load  = (w_opcode == OP_LOAD);
    assign w_is_store = (w_opcode == OP_STORE);
    assign w_reg_bad  = RV32E && ((w_uses_rd  && w_rd[4])  ||
                                  (w_uses_rs1 && w_rs1[4]) ||
                                  (w_uses_rs2 && w_rs2[4]));

    // Decode: legality, register usage and immediate construction
    always_comb begin
        w_legal    = 1'b0;
        w_trap     = 1'b0;
        w_uses_rd  = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_imm      = 32'h0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                w_legal   = 1'b1;
                w_uses_rd = 1'b1;
                w_imm     = {r_ir[31:12], 12'h000};
            end
            OP_JAL: begin
                w_legal   = 1'b1;
                w_uses_rd = 1'b1;
                w_imm     = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            end
            OP_JALR: begin
                w_legal    = (w_f3 == 3'b000);
                w_uses_rd  = 1'b1;
                w_uses_rs1 = 1'b1;
                w_imm      = {{20{r_ir[31]}}, r_ir[31:20]};
            end
            OP_BRANCH: begin
                w_legal    = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm      = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            end
            OP_LOAD: begin
                w_legal    = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                w_uses_rd  = 1'b1;
                w_uses_rs1 = 1'b1;
                w_imm      = {{20{r_ir[31]}}, r_ir[31:20]};
            end
            OP_STORE: begin
                w_legal    = (w_f3[2] == 1'b0) && (w_f3[1:0] != 2'b11);
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm      = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            end
            OP_IMM: begin
                case (w_f3)
                    3'b001:  w_legal = (w_f7 == 7'b0000000);
                    3'b101:  w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    default: w_legal = 1'b1;
                endcase
                w_uses_rd  = 1'b1;
                w_uses_rs1 = 1'b1;
                w_imm      = {{20{r_ir[31]}}, r_ir[31:20]};
            end
            OP_OP: begin
                w_legal    = (w_f7 == 7'b0000000) ||
                             ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_uses_rd  = 1'b1;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_FENCE: begin
                w_legal = (w_f3 == 3'b000);
            end
            OP_SYSTEM: begin
                if ((r_ir == 32'h0000_0073) || (r_ir == 32'h0010_0073)) begin
                    w_legal = 1'b1;
                    w_trap  = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    logic [31:0] w_alu_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu;
    logic [31:0] w_result;
    logic        w_taken;
    logic [31:0] w_next_pc;
    logic [31:0] w_addr;
    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    // Execute: ALU, branch condition, next PC, effective address and store lanes
    always_comb begin
        if (w_opcode == OP_OP) begin
            w_alu_b = r_rs2v;
        end else begin
            w_alu_b = r_imm;
        end
        w_shamt = w_alu_b[4:0];

        case (w_f3)
            3'b000: begin
                if ((w_opcode == OP_OP) && w_f7[5]) begin
                    w_alu = r_rs1v - w_alu_b;
                end else begin
                    w_alu = r_rs1v + w_alu_b;
                end
            end
            3'b001: w_alu = r_rs1v << w_shamt;
            3'b010: w_alu = {31'd0, ($signed(r_rs1v) < $signed(w_alu_b))};
            3'b011: w_alu = {31'd0, (r_rs1v < w_alu_b)};
            3'b100: w_alu = r_rs1v ^ w_alu_b;
            3'b101: begin
                if (w_f7[5]) begin
                    w_alu = $unsigned($signed(r_rs1v) >>> w_shamt);
                end else begin
                    w_alu = r_rs1v >> w_shamt;
                end
            end
            3'b110: w_alu = r_rs1v | w_alu_b;
            3'b111: w_alu = r_rs1v & w_alu_b;
            default: w_alu = 32'h0;
        endcase

        case (w_opcode)
            OP_LUI:          w_result = r_imm;
            OP_AUIPC:        w_result = r_pc + r_imm;
            OP_JAL, OP_JALR: w_result = r_pc + 32'd4;
            OP_OP, OP_IMM:   w_result = w_alu;
            default:         w_result = 32'h0;
        endcase

        case (w_f3)
            3'b000:  w_taken = (r_rs1v == r_rs2v);
            3'b001:  w_taken = (r_rs1v != r_rs2v);
            3'b100:  w_taken = ($signed(r_rs1v) <  $signed(r_rs2v));
            3'b101:  w_taken = ($signed(r_rs1v) >= $signed(r_rs2v));
            3'b110:  w_taken = (r_rs1v <  r_rs2v);
            3'b111:  w_taken = (r_rs1v >= r_rs2v);
            default: w_taken = 1'b0;
        endcase

        case (w_opcode)
            OP_BRANCH: begin
                if (w_taken) begin
                    w_next_pc = r_pc + r_imm;
                end else begin
                    w_next_pc = r_pc + 32'd4;
                end
            end
            OP_JAL:  w_next_pc = r_pc + r_imm;
            OP_JALR: w_next_pc = (r_rs1v + r_imm) & 32'hFFFF_FFFE;
            default: w_next_pc = r_pc + 32'd4;
        endcase

        w_addr = r_rs1v + r_imm;

        if (w_next_pc[1]) begin
            w_misaligned = 1'b1;
        end else if (w_is_load || w_is_store) begin
            w_misaligned = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                           ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
        end else begin
            w_misaligned = 1'b0;
        end

        case (w_f3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << w_addr[1:0];
                w_wdata = {4{r_rs2v[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << w_addr[1:0];
                w_wdata = {2{r_rs2v[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = r_rs2v;
            end
        endcase
    end

    logic [31:0] w_lane;
    logic [31:0] w_load;

    // Load lane extraction and sign/zero extension from the returned word
    always_comb begin
        w_lane = mem_rdata >> {r_addr[1:0], 3'b000};
        case (w_f3)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {24'h0, w_lane[7:0]};
            3'b101:  w_load = {16'h0, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    // Main control FSM with latched halt status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0;
            r_rs1v    <= 32'h0;
            r_rs2v    <= 32'h0;
            r_imm     <= 32'h0;
            r_result  <= 32'h0;
            r_next_pc <= 32'h0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_halted  <= 1'b0;
            r_cause   <= 2'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal || w_reg_bad) begin
                        r_halted <= 1'b1;
                        r_cause  <= CAUSE_ILLEGAL;
                        r_state  <= S_HALT;
                    end else if (w_trap) begin
                        r_halted <= 1'b1;
                        r_cause  <= CAUSE_TRAP;
                        r_state  <= S_HALT;
                    end else begin
                        r_rs1v  <= r_regs[w_rs1[RW-1:0]];
                        r_rs2v  <= r_regs[w_rs2[RW-1:0]];
                        r_imm   <= w_imm;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_misaligned) begin
                        r_halted <= 1'b1;
                        r_cause  <= CAUSE_ALIGN;
                        r_state  <= S_HALT;
                    end else begin
                        r_result  <= w_result;
                        r_next_pc <= w_next_pc;
                        r_addr    <= w_addr;
                        if (w_is_store) begin
                            r_wdata <= w_wdata;
                            r_wstrb <= w_wstrb;
                        end
                        if (w_is_load || w_is_store) begin
                            r_state <= S_MEM;
                        end else begin
                            r_state <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_load) begin
                            r_result <= w_load;
                        end
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_pc    <= r_next_pc;
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_halted <= 1'b1;
                    r_cause  <= CAUSE_ILLEGAL;
                    r_state  <= S_HALT;
                end
            endcase
        end
    end

    // Register file: written only in WB; x0 is never written so it reads 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if ((r_state == S_WB) && w_uses_rd && (w_rd != 5'd0)) begin
            r_regs[w_rd[RW-1:0]] <= r_result;
        end
    end

    // Memory port: request is live only in FETCH and MEM, and drops at once in reset
    assign mem_req   = rst && ((r_state == S_FETCH) || (r_state == S_MEM));
    assign mem_we    = rst && (r_state == S_MEM) && w_is_store;
    assign mem_addr  = !rst ? 32'h0 : ((r_state == S_MEM) ? r_addr : r_pc);
    assign mem_wdata = r_wdata;
    assign mem_wstrb = mem_we ? r_wstrb : 4'h0;

    assign pc_o       = r_pc;
    assign halted     = r_halted;
    assign halt_cause = r_cause;

`ifdef CPU_MC_PERF_EN
    logic [63:0] r_cycle;
    logic [63:0] r_instret;

    // Performance counters: running cycles and retired instructions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle   <= 64'h0;
            r_instret <= 64'h0;
        end else begin
            if (!r_halted) begin
                r_cycle <= r_cycle + 64'd1;
            end
            if (r_state == S_WB) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
`else
    assign cycle_cnt   = 64'h0;
    assign instret_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc: one RV32I instance on a word
// memory model with controllable mem_ready, plus an RV32E instance that
// always fetches ADDI x20,x0,1.
module tb_cpu_mc;

    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
    logic [3:0]  mem_wstrb;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [63:0] cycle_cnt, instret_cnt;

    logic        e_req, e_we, e_halted;
    logic [31:0] e_addr, e_wdata, e_pc;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_cause;
    logic [63:0] e_cyc, e_ins;

    logic [31:0] prog [256];
    logic [31:0] mem  [256];
    logic        load_en;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp64;

    cpu_mc #(.RESET_PC(32'h0), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_o(pc_o),
        .halted(halted), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    cpu_mc #(.RESET_PC(32'h0), .NUM_REGS(16)) dut_e (
        .clk(clk), .rst(rst), .mem_req(e_req), .mem_we(e_we),
        .mem_addr(e_addr), .mem_wdata(e_wdata), .mem_wstrb(e_wstrb),
        .mem_rdata(32'h00100A13), .mem_ready(1'b1), .pc_o(e_pc),
        .halted(e_halted), .halt_cause(e_cause),
        .cycle_cnt(e_cyc), .instret_cnt(e_ins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else if (mem_req && mem_we && mem_ready) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            last_wdata <= mem_wdata;
            last_wstrb <= mem_wstrb;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    endtask

    // Hold reset, copy prog into memory, release on a falling edge.
    task automatic apply_reset();
        rst = 1'b0;
        mem_ready = 1'b1;
        load_en = 1'b1;
        tick(2);
        load_en = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_ready = 1'b1;
        tick(1);
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_wstrb !== 4'h0) $display("FAIL rst_wstrb: got %h want 0", mem_wstrb); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if ({halted, halt_cause} !== 3'b000) $display("FAIL rst_halt: got %b%h want 0", halted, halt_cause); else n_pass++;
        n_checks++; if (pc_o !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc_o); else n_pass++;
        n_checks++; if ((cycle_cnt | instret_cnt) !== 64'h0) $display("FAIL rst_cnt: got %h/%h want 0", cycle_cnt, instret_cnt); else n_pass++;
    endtask

    task automatic test_alu();
        clear_prog();
        prog[0] = 32'h00500093;   // ADDI x1,x0,5
        prog[1] = 32'hFF908113;   // ADDI x2,x1,-7
        prog[2] = 32'h00202023;   // SW   x2,0(x0)
        prog[3] = 32'h00100183;   // LB   x3,1(x0)
        prog[4] = 32'h00205203;   // LHU  x4,2(x0)
        apply_reset();
        tick(7);
        n_checks++; if (pc_o !== 32'h4) $display("FAIL alu_pc7: got %h want 4", pc_o); else n_pass++;
        tick(1);
        n_checks++; if (pc_o !== 32'h8) $display("FAIL alu_pc8: got %h want 8", pc_o); else n_pass++;
        n_checks++; if (dut.r_regs[1] !== 32'h5) $display("FAIL alu_x1: got %h want 5", dut.r_regs[1]); else n_pass++;
        n_checks++; if (dut.r_regs[2] !== 32'hFFFF_FFFE) $display("FAIL alu_x2: got %h want fffffffe", dut.r_regs[2]); else n_pass++;
`ifdef CPU_MC_PERF_EN
        exp64 = 64'd2;
`else
        exp64 = 64'd0;
`endif
        n_checks++; if (instret_cnt !== exp64) $display("FAIL alu_instret: got %0d want %0d", instret_cnt, exp64); else n_pass++;
    endtask

    task automatic test_mem();
        tick(4);
        n_checks++; if (pc_o !== 32'h8) $display("FAIL sw_pc12: got %h want 8", pc_o); else n_pass++;
        n_checks++; if (last_wstrb !== 4'b1111) $display("FAIL sw_wstrb: got %b want 1111", last_wstrb); else n_pass++;
        n_checks++; if (last_wdata !== 32'hFFFF_FFFE) $display("FAIL sw_wdata: got %h want fffffffe", last_wdata); else n_pass++;
        n_checks++; if (mem[0] !== 32'hFFFF_FFFE) $display("FAIL sw_mem: got %h want fffffffe", mem[0]); else n_pass++;
        tick(1);
        n_checks++; if (pc_o !== 32'hC) $display("FAIL sw_pc13: got %h want c", pc_o); else n_pass++;
        tick(5);
        n_checks++; if (pc_o !== 32'h10) $display("FAIL lb_pc: got %h want 10", pc_o); else n_pass++;
        n_checks++; if (dut.r_regs[3] !== 32'hFFFF_FFFF) $display("FAIL lb_x3: got %h want ffffffff", dut.r_regs[3]); else n_pass++;
        tick(5);
        n_checks++; if (pc_o !== 32'h14) $display("FAIL lhu_pc: got %h want 14", pc_o); else n_pass++;
        n_checks++; if (dut.r_regs[4] !== 32'h0000_FFFF) $display("FAIL lhu_x4: got %h want 0000ffff", dut.r_regs[4]); else n_pass++;
    endtask

    task automatic test_wait_states();
        clear_prog();
        prog[0] = 32'h00100093;   // ADDI x1,x0,1
        apply_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL ws_req%0d: got req=%b we=%b want 1/0", i, mem_req, mem_we); else n_pass++;
            n_checks++; if (mem_addr !== 32'h0) $display("FAIL ws_addr%0d: got %h want 0", i, mem_addr); else n_pass++;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        tick(3);
        n_checks++; if (pc_o !== 32'h0) $display("FAIL ws_pc6: got %h want 0", pc_o); else n_pass++;
        tick(1);
        n_checks++; if (pc_o !== 32'h4) $display("FAIL ws_pc7: got %h want 4", pc_o); else n_pass++;
        n_checks++; if (dut.r_regs[1] !== 32'h1) $display("FAIL ws_x1: got %h want 1", dut.r_regs[1]); else n_pass++;
    endtask

    task automatic test_branch_jump();
        clear_prog();
        prog[0] = 32'h00100093;   // ADDI x1,x0,1
        prog[1] = 32'h10200393;   // ADDI x7,x0,0x102
        prog[2] = 32'h00009463;   // BNE  x1,x0,+8  -> 0x10
        prog[3] = 32'h00000093;   // ADDI x1,x0,0   (skipped)
        prog[4] = 32'h010002EF;   // JAL  x5,+16    -> 0x20
        prog[8] = 32'h00038367;   // JALR x6,0(x7)  -> 0x102 misaligned
        apply_reset();
        tick(12);
        n_checks++; if (pc_o !== 32'h10) $display("FAIL bne_pc: got %h want 10", pc_o); else n_pass++;
        tick(4);
        n_checks++; if (pc_o !== 32'h20) $display("FAIL jal_pc: got %h want 20", pc_o); else n_pass++;
        n_checks++; if (dut.r_regs[5] !== 32'h14) $display("FAIL jal_x5: got %h want 14", dut.r_regs[5]); else n_pass++;
        n_checks++; if (dut.r_regs[1] !== 32'h1) $display("FAIL bne_skip: got %h want 1", dut.r_regs[1]); else n_pass++;
        tick(2);
        n_checks++; if (halted !== 1'b0) $display("FAIL jalr_early: got %b want 0", halted); else n_pass++;
        tick(4);
        n_checks++; if (halted !== 1'b1 || halt_cause !== 2'd2) $display("FAIL jalr_halt: got %b/%0d want 1/2", halted, halt_cause); else n_pass++;
        n_checks++; if (pc_o !== 32'h20) $display("FAIL jalr_pc: got %h want 20", pc_o); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL jalr_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (dut.r_regs[6] !== 32'h0) $display("FAIL jalr_x6: got %h want 0", dut.r_regs[6]); else n_pass++;
`ifdef CPU_MC_PERF_EN
        exp64 = 64'd19;
`else
        exp64 = 64'd0;
`endif
        n_checks++; if (cycle_cnt !== exp64) $display("FAIL halt_cycles: got %0d want %0d", cycle_cnt, exp64); else n_pass++;
    endtask

    task automatic test_ecall();
        clear_prog();
        prog[0] = 32'h00000073;   // ECALL
        apply_reset();
        tick(1);
        n_checks++; if (halted !== 1'b0) $display("FAIL ecall_early: got %b want 0", halted); else n_pass++;
        tick(1);
        n_checks++; if (halted !== 1'b1 || halt_cause !== 2'd3) $display("FAIL ecall_halt: got %b/%0d want 1/3", halted, halt_cause); else n_pass++;
    endtask

    task automatic test_rv32e();
        clear_prog();
        apply_reset();
        tick(1);
        n_checks++; if (e_halted !== 1'b0) $display("FAIL e_early: got %b want 0", e_halted); else n_pass++;
        tick(1);
        n_checks++; if (e_halted !== 1'b1 || e_cause !== 2'd1) $display("FAIL e_halt: got %b/%0d want 1/1", e_halted, e_cause); else n_pass++;
        tick(3);
        n_checks++; if (e_req !== 1'b0) $display("FAIL e_req: got %b want 0", e_req); else n_pass++;
        n_checks++; if (e_pc !== 32'h0) $display("FAIL e_pc: got %h want 0", e_pc); else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        clear_prog();
        prog[0] = 32'h00500093;   // ADDI x1,x0,5
        prog[1] = 32'h04102023;   // SW   x1,64(x0)
        apply_reset();
        tick(7);
        mem_ready = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40) $display("FAIL mid_mem: got req=%b we=%b addr=%h want 1/1/40", mem_req, mem_we, mem_addr); else n_pass++;
        tick(1);
        rst = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL mid_rst_req: got req=%b we=%b want 0/0", mem_req, mem_we); else n_pass++;
        n_checks++; if (pc_o !== 32'h0) $display("FAIL mid_rst_pc: got %h want 0", pc_o); else n_pass++;
        n_checks++; if (dut.r_regs[1] !== 32'h0) $display("FAIL mid_rst_x1: got %h want 0", dut.r_regs[1]); else n_pass++;
        tick(1);
        n_checks++; if (mem[16] !== 32'h0) $display("FAIL mid_rst_mem: got %h want 0", mem[16]); else n_pass++;
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL restart_fetch: got req=%b addr=%h want 1/0", mem_req, mem_addr); else n_pass++;
        tick(4);
        n_checks++; if (pc_o !== 32'h4 || dut.r_regs[1] !== 32'h5) $display("FAIL restart_exec: got pc=%h x1=%h want 4/5", pc_o, dut.r_regs[1]); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        mem_ready = 1'b1;
        load_en = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_wait_states();
        test_branch_jump();
        test_ecall();
        test_rv32e();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
